// File: rtl/force_release_driver.sv
// Table-sequenced stimulus driver with a synthesizable force/release override on its output.
// Define FORCE_TIMEOUT_EN to build an auto-release counter for the override.
module force_release_driver #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned HOLD_CYCLES   = 5,
    parameter int unsigned FORCE_TIMEOUT = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     start,
    input  logic                     force_req,
    input  logic [WIDTH-1:0]         force_val,
    input  logic                     release_req,
    output logic [WIDTH-1:0]         out_val,
    output logic                     forced,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW-1:0] IdxLast  = AW'(DEPTH - 1);
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLD_CYCLES < 1 || FORCE_TIMEOUT < 1)
    begin : g_bad_params
        $error("force_release_driver: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW-1:0]      idx_nxt;
    logic [HW-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]   live_q, live_d;
    logic [WIDTH-1:0]   force_reg_q, force_reg_d;
    logic               forced_q, forced_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               accept_cmd;
    logic               tmo_expired;

    logic [WIDTH-1:0]   table_q [DEPTH];

`ifdef FORCE_TIMEOUT_EN
    localparam int unsigned TW = (FORCE_TIMEOUT > 1) ? $clog2(FORCE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(FORCE_TIMEOUT - 1);

    logic [TW-1:0] tmo_q;

    // Counts cycles since the last accepted force; saturates at the expiry value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (force_req && !release_req) begin
            tmo_q <= '0;
        end else if (forced_q && tmo_q != TmoLast) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_expired = forced_q && (tmo_q == TmoLast);
`else
    assign tmo_expired = 1'b0;
`endif

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        live_d     = live_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        accept_cmd = (state_q != StRun);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    hold_d  = '0;
                    live_d  = table_q[0];
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                if (hold_q == HoldLast) begin
                    hold_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_nxt;
                        live_d = table_q[idx_nxt];
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Override path: release beats a simultaneous force, which leaves force_reg untouched.
    always_comb begin
        forced_d    = forced_q;
        force_reg_d = force_reg_q;
        if (release_req) begin
            forced_d = 1'b0;
        end else if (force_req) begin
            forced_d    = 1'b1;
            force_reg_d = force_val;
        end else if (tmo_expired) begin
            forced_d = 1'b0;
        end
        out_d = forced_d ? force_reg_d : live_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            hold_q      <= '0;
            live_q      <= '0;
            force_reg_q <= '0;
            forced_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            live_q      <= live_d;
            force_reg_q <= force_reg_d;
            forced_q    <= forced_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_q       <= out_d;
        end
    end

    // Table storage is deliberately left unreset; writes are dropped while a sequence runs.
    always_ff @(posedge clk) begin
        if (load_en && accept_cmd) begin
            table_q[load_addr] <= load_data;
        end
    end

    assign out_val = out_q;
    assign forced  = forced_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_force_release_driver.sv
// Self-checking bench for force_release_driver: spec-derived vector tables for the
// documented scenarios, then random stimulus against a cycle-arithmetic reference model.
module tb_force_release_driver;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int H  = 5;
    localparam int TO = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_en;
    logic [2:0]   load_addr;
    logic [W-1:0] load_data;
    logic         start;
    logic         force_req;
    logic [W-1:0] force_val;
    logic         release_req;
    logic [W-1:0] out_val;
    logic         forced;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    force_release_driver #(
        .WIDTH        (W),
        .DEPTH        (D),
        .HOLD_CYCLES  (H),
        .FORCE_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .force_req  (force_req),
        .force_val  (force_val),
        .release_req(release_req),
        .out_val    (out_val),
        .forced     (forced),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    logic [6:0] act;
    assign act = {out_val, forced, busy, done};

    // Reference model: a run started on edge n shows entry k on cycles n+1+k*H .. n+(k+1)*H.
    logic [W-1:0] mtbl [D];
    bit           has_run;
    int           run_n;
    logic [W-1:0] m_last;
    bit           m_forced;
    logic [W-1:0] m_fval;
    int           m_tmo;
    logic [6:0]   exp_pk;

    function automatic logic [6:0] pk(logic [3:0] o, logic f, logic b, logic d);
        return {o, f, b, d};
    endfunction

    task automatic model_reset();
        has_run  = 0;
        run_n    = 0;
        m_last   = '0;
        m_forced = 0;
        m_fval   = '0;
        m_tmo    = 0;
        exp_pk   = '0;
    endtask

    task automatic model_edge(input int e);
        int           c;
        bit           running;
        bit           b;
        logic [W-1:0] under;
        running = has_run && (e >= run_n + 1) && (e <= run_n + D * H);
        if (!running) begin
            if (load_en) mtbl[load_addr] = load_data;
            if (start) begin
                has_run = 1;
                run_n   = e;
            end
        end
        if (release_req) begin
            m_forced = 0;
        end else if (force_req) begin
            m_forced = 1;
            m_fval   = force_val;
            m_tmo    = e;
        end
`ifdef FORCE_TIMEOUT_EN
        else if (m_forced && (e - m_tmo == TO)) begin
            m_forced = 0;
        end
`endif
        if (has_run && e == run_n + D * H) m_last = mtbl[D-1];
        c = e + 1;
        b = has_run && (c >= run_n + 1) && (c <= run_n + D * H);
        under = b ? mtbl[(c - run_n - 1) / H] : m_last;
        exp_pk = pk(m_forced ? m_fval : under, m_forced, b, has_run && (c == run_n + D * H + 1));
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got out=%0d forced=%b busy=%b done=%b want out=%0d forced=%b busy=%b done=%b",
                     name, ecnt, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic clear_inputs();
        load_en     = 0;
        load_addr   = '0;
        load_data   = '0;
        start       = 0;
        force_req   = 0;
        force_val   = '0;
        release_req = 0;
    endtask

    // Inputs set at the negedge are sampled on the next posedge; the model follows that edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge(ecnt);
        ecnt++;
        @(negedge clk);
    endtask

    typedef struct {
        int         cyc;
        bit         st;
        bit         fr;
        bit         rl;
        bit         ld;
        logic [3:0] fv;
        bit         ck;
        logic [6:0] ex;
        string      nm;
    } vec_t;

    vec_t vq[$];

    task automatic add_in(input int c, input bit st, input bit fr, input bit rl, input bit ld,
                          input logic [3:0] fv);
        vec_t v;
        v.cyc = c; v.st = st; v.fr = fr; v.rl = rl; v.ld = ld; v.fv = fv;
        v.ck = 0; v.ex = '0; v.nm = "";
        vq.push_back(v);
    endtask

    task automatic add_ck(input int c, input logic [6:0] ex, input string nm);
        vec_t v;
        v.cyc = c; v.st = 0; v.fr = 0; v.rl = 0; v.ld = 0; v.fv = '0;
        v.ck = 1; v.ex = ex; v.nm = nm;
        vq.push_back(v);
    endtask

    // Relative cycle e is the interval just before relative edge e; checks first, then inputs.
    task automatic run_scen(input int len);
        for (int e = 0; e <= len; e++) begin
            foreach (vq[i]) if (vq[i].ck && vq[i].cyc == e) check(vq[i].nm, vq[i].ex);
            check("model", exp_pk);
            clear_inputs();
            foreach (vq[i]) begin
                if (!vq[i].ck && vq[i].cyc == e) begin
                    if (vq[i].st) start = 1;
                    if (vq[i].fr) begin force_req = 1; force_val = vq[i].fv; end
                    if (vq[i].rl) release_req = 1;
                    if (vq[i].ld) begin load_en = 1; load_addr = '0; load_data = vq[i].fv; end
                end
            end
            tick();
        end
        clear_inputs();
        vq.delete();
    endtask

    logic [3:0] init_vals [D];

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", ecnt);
        $fatal(1);
    end

    initial begin
        init_vals = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd5, 4'd5};
        for (int i = 0; i < D; i++) mtbl[i] = '0;
        clear_inputs();
        model_reset();
        #1;
        check("reset_async", pk(0, 0, 0, 0));
        repeat (2) tick();
        check("reset_hold", pk(0, 0, 0, 0));
        rst = 0;

        for (int i = 0; i < D; i++) begin
            load_en = 1; load_addr = 3'(i); load_data = init_vals[i];
            tick();
        end
        clear_inputs();
        check("idle_after_load", pk(0, 0, 0, 0));

        // Plain sequence with start and load ignored mid-run.
        add_in(0, 1, 0, 0, 0, 0);
        add_in(10, 1, 0, 0, 0, 0);
        add_in(11, 0, 0, 0, 1, 15);
        add_ck(0,  pk(0, 0, 0, 0), "seq_idle");
        add_ck(1,  pk(2, 0, 1, 0), "seq_c1");
        add_ck(5,  pk(2, 0, 1, 0), "seq_c5");
        add_ck(6,  pk(4, 0, 1, 0), "seq_c6");
        add_ck(11, pk(6, 0, 1, 0), "seq_c11");
        add_ck(16, pk(8, 0, 1, 0), "seq_c16");
        add_ck(31, pk(5, 0, 1, 0), "seq_c31");
        add_ck(40, pk(5, 0, 1, 0), "seq_c40");
        add_ck(41, pk(5, 0, 0, 1), "seq_done");
        add_ck(42, pk(5, 0, 0, 0), "seq_after_done");
        run_scen(47);

        // Force 14 at edge 8, release at edge 17; table entry 0 must still be 2.
        add_in(0, 1, 0, 0, 0, 0);
        add_in(8, 0, 1, 0, 0, 14);
        add_in(17, 0, 0, 1, 0, 0);
        add_ck(0,  pk(5, 0, 0, 0), "done_holds_last");
        add_ck(1,  pk(2, 0, 1, 0), "load_dropped");
        add_ck(8,  pk(4, 0, 1, 0), "frc_before");
        add_ck(9,  pk(14, 1, 1, 0), "frc_c9");
        add_ck(17, pk(14, 1, 1, 0), "frc_c17");
        add_ck(18, pk(8, 0, 1, 0), "rel_c18");
        add_ck(20, pk(8, 0, 1, 0), "rel_c20");
        add_ck(21, pk(10, 0, 1, 0), "rel_c21");
        add_ck(41, pk(5, 0, 0, 1), "frc_run_done");
        run_scen(47);

        // Force and release on the same edge while forced: release wins.
        add_in(0, 1, 0, 0, 0, 0);
        add_in(10, 0, 1, 0, 0, 1);
        add_in(12, 0, 1, 1, 0, 9);
        add_ck(11, pk(1, 1, 1, 0), "col_forced");
        add_ck(12, pk(1, 1, 1, 0), "col_before");
        add_ck(13, pk(6, 0, 1, 0), "col_release");
        add_ck(14, pk(6, 0, 1, 0), "col_live");
        run_scen(47);

        // Force held across the end of the sequence.
        add_in(0, 1, 0, 0, 0, 0);
        add_in(38, 0, 1, 0, 0, 3);
        add_in(45, 0, 0, 1, 0, 0);
        add_ck(38, pk(5, 0, 1, 0), "end_before");
        add_ck(39, pk(3, 1, 1, 0), "end_forced");
        add_ck(41, pk(3, 1, 0, 1), "end_done_forced");
        add_ck(42, pk(3, 1, 0, 0), "end_after_done");
        add_ck(45, pk(3, 1, 0, 0), "end_still_forced");
        add_ck(46, pk(5, 0, 0, 0), "end_release");
        run_scen(47);

`ifdef FORCE_TIMEOUT_EN
        add_in(0, 1, 0, 0, 0, 0);
        add_in(8, 0, 1, 0, 0, 7);
        add_ck(17, pk(7, 1, 1, 0), "tmo_still_forced");
        add_ck(18, pk(8, 0, 1, 0), "tmo_expired");
        run_scen(47);
`endif

        // Asynchronous reset in the middle of a forced run.
        start = 1;
        tick();
        clear_inputs();
        repeat (6) tick();
        force_req = 1; force_val = 4'd9;
        tick();
        clear_inputs();
        tick();
        check("pre_reset", exp_pk);
        #2 rst = 1;
        #1;
        model_reset();
        check("rst_async_mid", pk(0, 0, 0, 0));
        repeat (3) begin
            tick();
            check("rst_hold_mid", pk(0, 0, 0, 0));
        end
        rst = 0;
        tick();
        check("post_reset_idle", pk(0, 0, 0, 0));
        start = 1;
        tick();
        clear_inputs();
        check("table_kept", pk(2, 0, 1, 0));
        repeat (45) begin
            tick();
            check("post_reset_run", exp_pk);
        end

        // Random stimulus against the model, with rare resets.
        for (int i = 0; i < 3000; i++) begin
            check("rand", exp_pk);
            clear_inputs();
            if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                model_reset();
                tick();
                rst = 0;
            end else begin
                start       = ($urandom_range(0, 39) == 0);
                force_req   = ($urandom_range(0, 14) == 0);
                release_req = ($urandom_range(0, 14) == 0);
                force_val   = 4'($urandom);
                load_en     = !start && ($urandom_range(0, 3) == 0);
                load_addr   = 3'($urandom);
                load_data   = 4'($urandom);
                tick();
            end
        end
        clear_inputs();
        check("rand_final", exp_pk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
